// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: A, B, optional pedestrian phase, with emergency preemption.
// Optional feature macro: PED_SKIP_EN (skip the pedestrian phase when no call is latched).
module traffic_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int T_GREEN_A = 30,
    parameter int T_GREEN_B = 30,
    parameter int T_YELLOW  = 3,
    parameter int T_PED     = 15,
    parameter int T_PED_CLR = 3,
    parameter int T_ALLRED  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [9:0]       ped_req,
    input  logic             emerg,
    output logic [2:0]       phase,
    output logic             phase_start,
    output logic [9:0]       ped_pending,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [2:0] {
        P_A_GREEN   = 3'd0,
        P_A_YELLOW  = 3'd1,
        P_B_GREEN   = 3'd2,
        P_B_YELLOW  = 3'd3,
        P_PED_WALK  = 3'd4,
        P_PED_CLEAR = 3'd5,
        P_ALL_RED   = 3'd6,
        P_ILLEGAL   = 3'd7
    } phase_t;

    phase_t           cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, t_cur;
    logic [9:0]       pend_nxt;
    logic             at_end;

    function automatic logic [CNT_W-1:0] t_of(input phase_t p);
        case (p)
            P_A_GREEN:               t_of = CNT_W'(T_GREEN_A);
            P_B_GREEN:               t_of = CNT_W'(T_GREEN_B);
            P_A_YELLOW, P_B_YELLOW:  t_of = CNT_W'(T_YELLOW);
            P_PED_WALK:              t_of = CNT_W'(T_PED);
            P_PED_CLEAR:             t_of = CNT_W'(T_PED_CLR);
            P_ALL_RED:               t_of = CNT_W'(T_ALLRED);
            default:                 t_of = '0;
        endcase
    endfunction

    assign t_cur  = t_of(cur);
    assign at_end = (cnt == t_cur);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= P_A_GREEN;
            cnt         <= '0;
            ped_pending <= '0;
            phase_start <= 1'b0;
        end else begin
            cur         <= nxt;
            cnt         <= cnt_nxt;
            ped_pending <= pend_nxt;
            phase_start <= (nxt != cur);
        end
    end

    // next-state logic
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        case (cur)
            P_A_GREEN, P_B_GREEN, P_PED_WALK: begin
                // green/walk phases can be cut short by preemption
                if (tick) begin
                    if (emerg || at_end) begin
                        nxt     = phase_t'(cur + 3'd1);
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            P_A_YELLOW, P_B_YELLOW, P_PED_CLEAR: begin
                if (tick) begin
                    if (at_end) begin
                        cnt_nxt = '0;
                        if (emerg) begin
                            nxt = P_ALL_RED;
                        end else if (cur == P_A_YELLOW) begin
                            nxt = P_B_GREEN;
                        end else if (cur == P_B_YELLOW) begin
`ifdef PED_SKIP_EN
                            nxt = (|(ped_pending | ped_req)) ? P_PED_WALK : P_A_GREEN;
`else
                            nxt = P_PED_WALK;
`endif
                        end else begin
                            nxt = P_A_GREEN;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            P_ALL_RED: begin
                // counter saturates at the minimum dwell while held by emerg
                if (tick) begin
                    if (!emerg && (cnt >= t_cur)) begin
                        nxt     = P_A_GREEN;
                        cnt_nxt = '0;
                    end else if (cnt < t_cur) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            P_ILLEGAL: begin
                nxt     = P_ALL_RED;
                cnt_nxt = '0;
            end
        endcase

        if (nxt == P_PED_WALK && cur != P_PED_WALK)
            pend_nxt = '0;
        else if (cur == P_PED_WALK)
            pend_nxt = ped_pending;
        else
            pend_nxt = ped_pending | ped_req;
    end

    // outputs
    always_comb begin
        phase     = cur;
        remaining = (cur == P_ILLEGAL) ? '0 : (t_cur - cnt);
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic vs. a rule-level model.
module tb_traffic_phase_scheduler;

    localparam int CW  = 8;
    localparam int TGA = 4, TGB = 4, TY = 1, TP = 2, TPC = 1, TAR = 1;

    if (TGA >= (1 << CW) || TGB >= (1 << CW) || TY >= (1 << CW) ||
        TP >= (1 << CW) || TPC >= (1 << CW) || TAR >= (1 << CW)) begin : g_param_chk
        $fatal(1, "timing parameter does not fit the counter width");
    end

    logic          clk = 1'b0, rst, tick, emerg;
    logic [9:0]    ped_req, ped_pending;
    logic [2:0]    phase;
    logic          phase_start;
    logic [CW-1:0] remaining;

    traffic_phase_scheduler #(
        .CNT_W(CW), .T_GREEN_A(TGA), .T_GREEN_B(TGB), .T_YELLOW(TY),
        .T_PED(TP), .T_PED_CLR(TPC), .T_ALLRED(TAR)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .emerg(emerg),
        .phase(phase), .phase_start(phase_start), .ped_pending(ped_pending),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // reference model: phase number, tick count inside phase, latched calls
    int         m_ph, m_cnt, n_ph, n_cnt;
    logic [9:0] m_pend, n_pend;
    logic       m_ps, n_ps;

    function automatic int dur(input int p);
        case (p)
            0: return TGA;  1: return TY;  2: return TGB;  3: return TY;
            4: return TP;   5: return TPC; default: return TAR;
        endcase
    endfunction

    function automatic int follow(input int p);
        case (p)
            1: return 2;
            3: begin
`ifdef PED_SKIP_EN
                return ((m_pend | ped_req) != 0) ? 4 : 0;
`else
                return 4;
`endif
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_pend = '0; m_ps = 1'b0;
    endtask

    task automatic model_next();
        n_ph = m_ph; n_cnt = m_cnt;
        if (tick) begin
            if (m_ph == 6) begin
                if (!emerg && m_cnt >= TAR) begin n_ph = 0; n_cnt = 0; end
                else if (m_cnt < TAR) n_cnt = m_cnt + 1;
            end else if (m_ph == 0 || m_ph == 2 || m_ph == 4) begin
                if (emerg || m_cnt == dur(m_ph)) begin n_ph = m_ph + 1; n_cnt = 0; end
                else n_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == dur(m_ph)) begin n_ph = emerg ? 6 : follow(m_ph); n_cnt = 0; end
                else n_cnt = m_cnt + 1;
            end
        end
        if (n_ph == 4 && m_ph != 4) n_pend = '0;
        else if (m_ph == 4)         n_pend = m_pend;
        else                        n_pend = m_pend | ped_req;
        n_ps = (n_ph != m_ph);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("phase", 32'(phase), 32'(m_ph));
        chk("phase_start", 32'(phase_start), 32'(m_ps));
        chk("ped_pending", 32'(ped_pending), 32'(m_pend));
        chk("remaining", 32'(remaining), 32'(dur(m_ph) - m_cnt));
    endtask

    // one clk: predict, take the edge, compare 1 time unit later
    task automatic cyc();
        model_next();
        @(posedge clk);
        #1;
        m_ph = n_ph; m_cnt = n_cnt; m_pend = n_pend; m_ps = n_ps;
        chk_all();
    endtask

    task automatic bound_ok(input string tag, input int n);
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    int n;

    initial begin
        rst = 1'b1; tick = 1'b0; ped_req = '0; emerg = 1'b0;
        model_reset();
        #3;
        chk_all();
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b1;

        // free-running cycle with no calls
        repeat (40) cyc();

        // single pedestrian pulse during A_GREEN
        n = 0;
        while (!(m_ph == 0 && m_cnt == 1) && n < 200) begin cyc(); n++; end
        bound_ok("wait_a_green", n);
        ped_req = 10'h004;
        cyc();
        ped_req = '0;
        repeat (30) cyc();

        // emergency raised at cnt=1 of B_GREEN, held 10 ticks
        n = 0;
        while (!(m_ph == 2 && m_cnt == 1) && n < 200) begin cyc(); n++; end
        bound_ok("wait_b_green", n);
        emerg = 1'b1;
        repeat (10) cyc();
        chk("held_all_red", 32'(phase), 32'd6);
        emerg = 1'b0;
        repeat (20) cyc();

        // tick stalled mid A_GREEN
        n = 0;
        while (!(m_ph == 0 && m_cnt == 2) && n < 200) begin cyc(); n++; end
        bound_ok("wait_mid_a", n);
        tick = 1'b0;
        repeat (20) cyc();
        chk("frozen_remaining", 32'(remaining), 32'(TGA - 2));
        tick = 1'b1;
        repeat (10) cyc();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            tick    = ($urandom_range(0, 3) != 0);
            ped_req = ($urandom_range(0, 9) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'h000;
            if ($urandom_range(0, 39) == 0) emerg = ~emerg;
            cyc();
        end

        // asynchronous reset mid B_YELLOW with calls pending
        tick = 1'b1; emerg = 1'b0; ped_req = '0;
        n = 0;
        while (m_ph != 0 && n < 200) begin cyc(); n++; end
        bound_ok("wait_a_for_call", n);
        ped_req = 10'h201;
        cyc();
        ped_req = '0;
        n = 0;
        while (m_ph != 3 && n < 200) begin cyc(); n++; end
        bound_ok("wait_b_yellow", n);
        chk("pending_before_rst", 32'(ped_pending), 32'h201);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Sequences the intersection's signal phases: vehicle group A, then vehicle group B, then an exclusive pedestrian phase. Each phase has a configurable duration measured in ticks. The block emits a 3-bit phase code in the S1..S6 encoding already consumed by the light-pattern decoder, plus an all-red code. It latches pedestrian button calls, supports emergency preemption, and exposes the remaining time for display units.

## Interface
- CNT_W, 8, width of the tick counter and of `remaining`
- T_GREEN_A, 30, ticks−1 spent in A_GREEN
- T_GREEN_B, 30, ticks−1 spent in B_GREEN
- T_YELLOW, 3, ticks−1 spent in A_YELLOW and in B_YELLOW
- T_PED, 15, ticks−1 spent in PED_WALK
- T_PED_CLR, 3, ticks−1 spent in PED_CLEAR
- T_ALLRED, 2, minimum ticks−1 spent in ALL_RED
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle time-base enable (1 Hz strobe); all phase timing counts only cycles with tick=1
- ped_req  in  10  pedestrian buttons P1..P10; level or pulse, sampled every clk
- emerg  in  1  emergency preemption request, level
- phase  out  3  0 A_GREEN, 1 A_YELLOW, 2 B_GREEN, 3 B_YELLOW, 4 PED_WALK, 5 PED_CLEAR, 6 ALL_RED
- phase_start  out  1  high for exactly one clk on the first cycle of every new phase
- ped_pending  out  10  latched, not-yet-served pedestrian calls
- remaining  out  CNT_W  ticks left in the current phase (T_cur − cnt)

## Operation
- The phase register and the tick counter `cnt` are the only timing state. On a tick where cnt < T_cur, cnt increments. On a tick where cnt == T_cur, the block transitions to the next phase and cnt resets to 0. Each phase therefore lasts T_cur+1 ticks; T_cur = 0 gives a phase of one tick.
- Normal sequence: A_GREEN → A_YELLOW → B_GREEN → B_YELLOW. After B_YELLOW the block goes to PED_WALK or to A_GREEN according to the skip rule in Configuration. The pedestrian path continues PED_WALK → PED_CLEAR → A_GREEN.
- Pedestrian calls: in every clk, ped_pending ← ped_pending | ped_req.
  - On the clk where PED_WALK is entered, ped_pending clears to 0. A ped_req asserted on that same clk is also cleared, because it is served by this walk.
  - While in PED_WALK, ped_req is ignored.
  - In PED_CLEAR and all other phases, calls latch for the next cycle.
- Emergency: emerg is evaluated only at phase-exit or preemption points, on tick cycles.
  - In A_GREEN or B_GREEN with emerg=1 on a tick, the block moves immediately to the matching yellow phase with cnt=0, regardless of cnt.
  - In PED_WALK with emerg=1 on a tick, the block moves immediately to PED_CLEAR with cnt=0.
  - Yellow and PED_CLEAR always run to completion. At completion, emerg=1 sends the block to ALL_RED instead of the normal successor.
  - ALL_RED holds while emerg=1. It exits to A_GREEN on the first tick where emerg=0 and cnt ≥ T_ALLRED. While held, cnt saturates at T_ALLRED.
  - ped_pending keeps latching throughout preemption. It is not cleared by preemption.
- Illegal phase code 7 goes to ALL_RED on the next clk, regardless of tick, with cnt=0.
- remaining = T_cur − cnt for the current phase. It is combinational from registered state, so it never goes negative.

## Timing
- Reset values: phase=0 (A_GREEN), cnt=0, ped_pending=0, phase_start=0, remaining=T_GREEN_A.
- Releasing reset starts A_GREEN without a phase_start pulse.
- Transitions are registered on the clk edge of the deciding tick cycle. The new phase is visible in the next cycle, with phase_start=1 in that cycle.
- No transition or cnt change occurs on cycles with tick=0, except the illegal-code recovery.
- rst asserted mid-phase immediately forces the reset values, including clearing pending calls.
- Parameters must be < 2^CNT_W. The bench checks this with an elaboration assertion.

## Configuration
- PED_SKIP_EN defined: when leaving B_YELLOW, the block enters PED_WALK only if ped_pending ≠ 0 or ped_req ≠ 0 in the deciding cycle; otherwise it goes to A_GREEN.
- PED_SKIP_EN undefined: PED_WALK/PED_CLEAR always follow B_YELLOW (fixed six-phase cycle). ped_pending still latches and clears as specified.

## Test plan
- Bench parameters: T_GREEN_A=4, T_GREEN_B=4, T_YELLOW=1, T_PED=2, T_PED_CLR=1, T_ALLRED=1, tick every clk.
- Reset, no calls, PED_SKIP_EN defined → phase dwell is 0×5, 1×2, 2×5, 3×2, then 0 again; codes 4/5 never appear; exactly four phase_start pulses per cycle.
- Same setup, PED_SKIP_EN undefined → dwell is 0×5, 1×2, 2×5, 3×2, 4×3, 5×2; remaining reads 4,3,2,1,0 in A_GREEN.
- ped_req=10'h004 pulsed one clk during A_GREEN (skip enabled) → ped_pending=10'h004 until PED_WALK entry, then 0; phase 4 lasts 3 ticks.
- emerg raised at cnt=1 of B_GREEN, held 10 ticks → next tick phase=3 for 2 ticks, then 6 held; after emerg drops, ALL_RED exits once cnt ≥ 1, then phase=0.
- tick held low for 20 clks mid-A_GREEN → phase and remaining frozen; rst asserted asynchronously mid-B_YELLOW with ped_pending≠0 → phase=0, ped_pending=0 before the next clk edge.
